pipelined_approx_rca: RTL

Parametrised, pipelined ripple-carry adder. It is the successor to the 4-bit combinational RCA_p.
- Operand width is split into STAGES equal segments; the carry ripples through one segment per clock.
- A per-transaction MODE bit selects exact addition or lower-part-OR approximation (LOA) on the lowest APPROX_BITS bits.
- Valid/ready handshakes on input and output let it sit in approximate-datapath experiments as a streaming arithmetic unit.

---
 rtl/approx_pkg.sv | 24 ++
 rtl/rca_segment.sv | 33 +++
 rtl/pipelined_approx_rca.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/approx_pkg.sv
// Shared definitions for the pipelined approximate ripple-carry adder:
// mode encoding and the elaboration-time parameter legality check.
package approx_pkg;

    localparam logic MODE_EXACT = 1'b0;
    localparam logic MODE_LOA   = 1'b1;

    // Segments must tile the operand exactly and the approximate part must fit in segment 0.
    function automatic bit params_legal(input int width, input int stages, input int approx_bits);
        bit ok;
        ok = 1'b1;
        if (stages < 1) begin
            ok = 1'b0;
        end else if ((width < stages) || ((width % stages) != 0)) begin
            ok = 1'b0;
        end else if ((approx_bits < 0) || (approx_bits > (width / stages))) begin
            ok = 1'b0;
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/rca_segment.sv
// Combinational SEG-bit ripple adder; when loa_en is set the lowest APPROX_BITS
// bits are OR-ed and the carry into the exact part is the AND of their top bit.
module rca_segment #(
    parameter int SEG         = 4,
    parameter int APPROX_BITS = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    input  logic           loa_en,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    logic carry_s;

    // Bitwise ripple; under LOA the incoming carry is overwritten, so cin drops out.
    always_comb begin
        sum     = {SEG{1'b0}};
        carry_s = cin;
        for (int i = 0; i < SEG; i++) begin
            if (loa_en && (i < APPROX_BITS)) begin
                sum[i]  = a[i] | b[i];
                carry_s = a[i] & b[i];
            end else begin
                sum[i]  = a[i] ^ b[i] ^ carry_s;
                carry_s = (a[i] & b[i]) | (carry_s & (a[i] ^ b[i]));
            end
        end
        cout = carry_s;
    end

endmodule

// File: rtl/pipelined_approx_rca.sv
// Pipelined ripple-carry adder: one SEG-bit segment per stage, carry registered
// between stages, optional lower-part-OR approximation selected per transaction.
module pipelined_approx_rca
    import approx_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int STAGES      = 4,
    parameter int APPROX_BITS = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             MODE,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OUT_MODE
);

    localparam int SEG = WIDTH / STAGES;

    if (!params_legal(WIDTH, STAGES, APPROX_BITS)) begin : g_param_check
        $error("pipelined_approx_rca: illegal WIDTH/STAGES/APPROX_BITS combination");
    end

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] mode_q, mode_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];

    logic [STAGES-1:0][SEG-1:0] seg_a_s, seg_b_s, seg_sum_s;
    logic [STAGES-1:0]          seg_cin_s, seg_cout_s, seg_loa_s;

    logic             advance_s;
    logic [WIDTH-1:0] op_a_s, op_b_s;
    logic             op_cin_s, op_loa_s, op_mode_s;
    logic             unused_skew_s;

    assign OUT_VALID = valid_q[STAGES-1];
    assign SUM       = sum_q[STAGES-1];
    assign COUT      = carry_q[STAGES-1];
    assign OUT_MODE  = mode_q[STAGES-1];
    assign IN_READY  = OUT_READY || !OUT_VALID;
    assign advance_s = IN_READY;

    // Bubbles enter as all-zero data so an idle pipeline never shows stale sums.
    always_comb begin
        if (IN_VALID) begin
            op_a_s    = A;
            op_b_s    = B;
            op_mode_s = MODE;
            op_loa_s  = (MODE == MODE_LOA) && (APPROX_BITS > 0);
            op_cin_s  = CIN;
        end else begin
            op_a_s    = {WIDTH{1'b0}};
            op_b_s    = {WIDTH{1'b0}};
            op_mode_s = MODE_EXACT;
            op_loa_s  = 1'b0;
            op_cin_s  = 1'b0;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign seg_a_s[k]   = op_a_s[SEG-1:0];
            assign seg_b_s[k]   = op_b_s[SEG-1:0];
            assign seg_cin_s[k] = op_cin_s;
            assign seg_loa_s[k] = op_loa_s;
        end else begin : g_rest
            assign seg_a_s[k]   = a_q[k-1][k*SEG +: SEG];
            assign seg_b_s[k]   = b_q[k-1][k*SEG +: SEG];
            assign seg_cin_s[k] = carry_q[k-1];
            assign seg_loa_s[k] = 1'b0;
        end

        rca_segment #(
            .SEG         (SEG),
            .APPROX_BITS (APPROX_BITS)
        ) u_seg (
            .a      (seg_a_s[k]),
            .b      (seg_b_s[k]),
            .cin    (seg_cin_s[k]),
            .loa_en (seg_loa_s[k]),
            .sum    (seg_sum_s[k]),
            .cout   (seg_cout_s[k])
        );
    end

    // Next-state of every stage: shift by one on advance, otherwise hold (global stall).
    always_comb begin
        valid_d = valid_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        a_d     = a_q;
        b_d     = b_q;
        if (advance_s) begin
            valid_d[0]            = IN_VALID;
            mode_d[0]             = op_mode_s;
            carry_d[0]            = seg_cout_s[0];
            sum_d[0]              = {WIDTH{1'b0}};
            sum_d[0][SEG-1:0]     = seg_sum_s[0];
            a_d[0]                = op_a_s;
            b_d[0]                = op_b_s;
            for (int k = 1; k < STAGES; k++) begin
                valid_d[k]             = valid_q[k-1];
                mode_d[k]              = mode_q[k-1];
                carry_d[k]             = seg_cout_s[k];
                sum_d[k]               = sum_q[k-1];
                sum_d[k][k*SEG +: SEG] = seg_sum_s[k];
                a_d[k]                 = a_q[k-1];
                b_d[k]                 = b_q[k-1];
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Skew-register bits below the active segment and the last stage's copy are never consumed.
    always_comb begin
        unused_skew_s = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            unused_skew_s = unused_skew_s ^ (^a_q[k]) ^ (^b_q[k]);
        end
    end

    // Pipeline registers with synchronous active-low reset discarding all in-flight work.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            valid_q <= {STAGES{1'b0}};
            mode_q  <= {STAGES{1'b0}};
            carry_q <= {STAGES{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= {WIDTH{1'b0}};
                a_q[k]   <= {WIDTH{1'b0}};
                b_q[k]   <= {WIDTH{1'b0}};
            end
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= sum_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
            end
        end
    end

endmodule
